// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared definitions for the parametrised serial sequence detector.
//   DEF_MAX_LEN / DEF_CNT_W : default pattern length limit and hit-counter width
//   mode_e                  : detection mode (overlapping / non-overlapping)
//   clamp_len()             : limits a requested pattern length to the supported maximum
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } mode_e;

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_det_history.sv
// seq_det_history: serial history shift register with a saturating fill counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   shift      : consume x this edge (history shifts left, fill counts up to MAX_LEN)
//   clear      : zero history and fill (wins over shift)
//   restart    : with shift, keep the shifted history but mark it invalid (fill=0)
//   x          : serial input bit
//   history    : most recent bits, newest in bit 0
//   fill       : number of valid bits in history, saturating at MAX_LEN
module seq_det_history
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int FILL_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift,
  input  logic               clear,
  input  logic               restart,
  input  logic               x,
  output logic [MAX_LEN-1:0] history,
  output logic [FILL_W-1:0]  fill
);

  function automatic logic [FILL_W-1:0] sat_fill(input logic [FILL_W-1:0] f);
    return (f == FILL_W'(MAX_LEN)) ? f : f + FILL_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history <= '0;
      fill    <= '0;
    end else if (clear) begin
      history <= '0;
      fill    <= '0;
    end else if (shift) begin
      history <= {history[MAX_LEN-2:0], x};
      fill    <= restart ? '0 : sat_fill(fill);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial bit-sequence detector.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : sample enable for x
//   x            : serial data bit
//   cfg_we       : latch cfg_pattern / cfg_len / cfg_overlap and restart the history
//   cfg_pattern  : pattern, bit [len-1] is the first bit received
//   cfg_len      : pattern length (clamped to MAX_LEN, 0 disables detection)
//   cfg_overlap  : 1 = overlapping matches allowed
//   cnt_clr      : synchronous clear of hit_cnt (wins over an increment)
//   z            : registered one-cycle match pulse
//   hit_cnt      : saturating match counter
//   busy         : detector enabled but history not yet holding len valid bits
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               x,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic               busy
);

  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  mode_e              mode;

  logic [MAX_LEN-1:0] history;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [LEN_W-1:0]   fill_nxt;
  logic [MAX_LEN-1:0] mask;
  logic               sample;
  logic               match;
  logic               hit;
  logic               restart;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // A configuration write owns the edge: x is dropped and no match can fire.
  assign sample = en & ~cfg_we;

  // Match is judged on the values the history will hold after this edge,
  // so z can be registered with one clock of latency from the last bit.
  assign hist_nxt = MAX_LEN'({history, x});
  assign fill_nxt = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign match   = (len != '0) && (fill_nxt >= len) &&
                   (((hist_nxt ^ pattern) & mask) == '0);
  assign hit     = sample & match;
  // Non-overlapping mode: the matched bits may not seed the next match.
  assign restart = hit & (mode == NON_OVERLAP);

  seq_det_history #(
    .MAX_LEN (MAX_LEN),
    .FILL_W  (LEN_W)
  ) u_history (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift   (sample),
    .clear   (cfg_we),
    .restart (restart),
    .x       (x),
    .history (history),
    .fill    (fill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= '0;
      len     <= '0;
      mode    <= OVERLAP;
    end else if (cfg_we) begin
      pattern <= cfg_pattern;
      len     <= LEN_W'(clamp_len(32'(cfg_len), 32'(MAX_LEN)));
      mode    <= mode_e'(cfg_overlap);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z       <= 1'b0;
      hit_cnt <= '0;
    end else begin
      z <= hit;
      if (cnt_clr) begin
        hit_cnt <= '0;
      end else if (hit) begin
        hit_cnt <= sat_inc(hit_cnt);
      end
    end
  end

  assign busy = (len != '0) && (fill < len);

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed scenarios plus randomized traffic for
// seq_detector_param, compared each cycle against a bit-queue reference model.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic               x = 1'b0;
  logic               cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               cnt_clr = 1'b0;
  logic               z;
  logic [CNT_W-1:0]   hit_cnt;
  logic               busy;

  always #5 clk = ~clk;

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .x           (x),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .z           (z),
    .hit_cnt     (hit_cnt),
    .busy        (busy)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Reference model: every bit received since the last config/reset, plus the
  // queue index from which bits count as valid for the next match.
  int     m_hist[$];
  int     m_since;
  int     m_len;
  longint m_pat;
  bit     m_ov;
  bit     m_z;
  int     m_cnt;
  bit     m_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_busy();
    int n;
    n = m_hist.size() - m_since;
    if (n > MAX_LEN) n = MAX_LEN;
    m_busy = (m_len != 0) && (n < m_len);
  endfunction

  function automatic void model_reset();
    m_hist.delete();
    m_since = 0;
    m_len   = 0;
    m_pat   = 0;
    m_ov    = 1'b1;
    m_z     = 1'b0;
    m_cnt   = 0;
    m_busy  = 1'b0;
  endfunction

  function automatic void model_edge();
    bit     hit;
    longint v;
    hit = 1'b0;
    if (cfg_we) begin
      m_pat   = longint'(cfg_pattern);
      m_len   = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
      m_ov    = cfg_overlap;
      m_hist.delete();
      m_since = 0;
    end else if (en) begin
      m_hist.push_back(int'(x));
      if (m_len != 0 && (m_hist.size() - m_since) >= m_len) begin
        v = 0;
        for (int k = m_len; k >= 1; k--) v = v * 2 + m_hist[m_hist.size() - k];
        hit = (v == (m_pat % (longint'(1) << m_len)));
      end
      if (hit && !m_ov) m_since = m_hist.size();
      while (m_hist.size() > 40) begin
        void'(m_hist.pop_front());
        if (m_since > 0) m_since--;
      end
    end
    m_z = hit;
    if (cnt_clr) m_cnt = 0;
    else if (hit && m_cnt < CNT_MAX) m_cnt++;
    model_busy();
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("z", z, m_z);
      check("hit_cnt", hit_cnt, m_cnt);
      check("busy", busy, m_busy);
    end
  end

  task automatic step(input bit e, input bit b, input bit c);
    en = e; x = b; cnt_clr = c; cfg_we = 1'b0;
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  // x=1, en=1 during the write so any would-be match must be suppressed.
  task automatic cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] l, input bit ov);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = l; cfg_overlap = ov;
    en = 1'b1; x = 1'b1; cnt_clr = 1'b0;
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_z", z, 1'b0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic stream(input int n, input logic [15:0] bits, input logic [15:0] exp_z,
                        input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0);
      check({tag, "_z"}, z, exp_z[i]);
    end
  endtask

  initial begin
    model_reset();
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // len=0: detector disabled
    stream(4, 16'b1111, 16'b0000, "idle");
    check("idle_cnt", hit_cnt, 0);

    // overlapping 1011
    cfg(8'b1011, 4'd4, 1'b1);
    check("ov_busy_cfg", busy, 1'b1);
    for (int i = 0; i < 7; i++) begin
      logic [6:0] bits;
      logic [6:0] ez;
      logic [6:0] eb;
      bits = 7'b1011011; ez = 7'b0001001; eb = 7'b1110000;
      step(1'b1, bits[6-i], 1'b0);
      check("ov_z", z, ez[6-i]);
      check("ov_busy", busy, eb[6-i]);
    end
    check("ov_cnt", hit_cnt, 2);

    // non-overlapping 1011
    step(1'b0, 1'b0, 1'b1);
    check("clr_cnt", hit_cnt, 0);
    cfg(8'b1011, 4'd4, 1'b0);
    stream(9, 16'b101101111, 16'b000100000, "nov");
    check("nov_cnt", hit_cnt, 1);

    // enable gating with pattern 11
    step(1'b0, 1'b0, 1'b1);
    cfg(8'b11, 4'd2, 1'b1);
    step(1'b1, 1'b1, 1'b0); check("en_z1", z, 1'b0);
    step(1'b0, 1'b0, 1'b0); check("en_z2", z, 1'b0);
    step(1'b1, 1'b1, 1'b0); check("en_z3", z, 1'b1);
    check("en_cnt", hit_cnt, 1);

    // cfg_we over a would-be match (history 11, x=1): no pulse, no count
    step(1'b0, 1'b0, 1'b1);
    cfg(8'b1, 4'd1, 1'b1);
    check("cfgwin_z", z, 1'b0);
    check("cfgwin_cnt", hit_cnt, 0);

    // saturation then clear together with a hit
    stream(5, 16'b11111, 16'b11111, "sat");
    check("sat_cnt", hit_cnt, 3);
    step(1'b1, 1'b1, 1'b1);
    check("satclr_cnt", hit_cnt, 0);
    check("satclr_z", z, 1'b1);

    // reconfiguration mid-stream
    cfg(8'b1011, 4'd4, 1'b1);
    stream(3, 16'b101, 16'b000, "rc_pre");
    cfg(8'b011, 4'd3, 1'b1);
    check("rc_z", z, 1'b0);
    check("rc_busy", busy, 1'b1);
    stream(3, 16'b011, 16'b001, "rc_post");

    // cfg_len beyond MAX_LEN clamps to MAX_LEN
    cfg(8'hA5, 4'd15, 1'b1);
    stream(7, 16'b1010010, 16'b0000000, "clamp_pre");
    check("clamp_busy7", busy, 1'b1);
    stream(1, 16'b1, 16'b1, "clamp_last");
    check("clamp_busy8", busy, 1'b0);

    // asynchronous reset mid-cycle, then fresh bits required
    cfg(8'b11, 4'd2, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    async_reset();
    cfg(8'b11, 4'd2, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check("postrst_z1", z, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("postrst_z2", z, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 4) begin
        logic [LEN_W-1:0] l;
        l = ($urandom_range(0, 9) < 8) ? LEN_W'($urandom_range(1, 4))
                                       : LEN_W'($urandom_range(0, 15));
        cfg(MAX_LEN'($urandom), l, 1'($urandom_range(0, 1)));
      end else if (r == 4) begin
        async_reset();
      end else begin
        step($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)),
             $urandom_range(0, 49) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
